// File: rtl/irq_pending_8.sv
// Eight-line edge-triggered interrupt pending register with per-line masking,
// sticky overrun flags and a single request/acknowledge handshake.
module irq_pending_8 (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iReq,
  input  logic [7:0] iMask,
  input  logic       iAck,
  input  logic [2:0] iAckId,
  input  logic       iClrLost,
  output logic [7:0] oPend,
  output logic       oIrq,
  output logic [7:0] oLost,
  output logic       oAckErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t     state;
  state_t     stateNext;

  logic [7:0] reqSync1;
  logic [7:0] reqSync2;
  logic [7:0] reqHist;
  logic [7:0] reqEdge;

  logic [7:0] pend;
  logic [7:0] pendNext;
  logic [7:0] lost;
  logic [7:0] lostNext;

  logic       ackValid;
  logic       ackHit;
  logic [7:0] ackVec;
  logic [7:0] clrVec;
  logic [7:0] overrun;
  logic       ackErr;

  // Request synchronizer and rising-edge detector
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      reqSync1 <= '0;
      reqSync2 <= '0;
      reqHist  <= '0;
    end else begin
      reqSync1 <= iReq;
      reqSync2 <= reqSync1;
      reqHist  <= reqSync2;
    end
  end

  assign reqEdge = reqSync2 & ~reqHist;

  // Acknowledges only count while the request is being presented
  assign ackValid = (state == ASSERT) && iAck;
  assign ackVec   = 8'b1 << iAckId;
  assign ackHit   = ackValid && pend[iAckId];
  assign clrVec   = ackHit ? ackVec : '0;

  // A new edge outranks a same-cycle clear, so it is never counted as lost
  assign overrun  = reqEdge & pend & ~clrVec;

  always_comb begin
    pendNext = (pend & ~clrVec) | reqEdge;
    lostNext = (iClrLost ? '0 : lost) | overrun;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pend    <= '0;
      lost    <= '0;
      oAckErr <= 1'b0;
    end else begin
      pend    <= pendNext;
      lost    <= lostNext;
      oAckErr <= ackErr;
    end
  end

  assign ackErr = ackValid && !pend[iAckId];

  assign oPend  = pend & ~iMask;
  assign oLost  = lost;

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (|oPend) begin
          stateNext = ASSERT;
        end
      end
      ASSERT: begin
        if (iAck) begin
          stateNext = GAP;
        end else if (!(|oPend)) begin
          stateNext = IDLE;
        end
      end
      GAP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    oIrq = 1'b0;
    if (state == ASSERT) begin
      oIrq = 1'b1;
    end
  end

endmodule
